// File: rtl/soc_system_pio_read_arbiter.sv
// soc_system_pio_read_arbiter
// Two-requester read arbiter in front of a single registered PIO.
// Exactly one read is in flight at a time. The arbiter accepts a command,
// waits a fixed PIO latency, captures the data, then returns a one-cycle
// readdatavalid strobe to the winner.
// Optional build macro: PIO_ARB_FIXED_PRIO_EN. When it is defined, requester 0
// always wins ties and there is no round-robin pointer. When it is undefined,
// arbitration is round-robin.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no read in flight; the arbitration winner sees waitrequest=0
// ST_WAIT    | PIO address is stable; count PIO_LATENCY+1 cycles
// ST_RESPOND | pulse readdatavalid to the owner for one cycle

module soc_system_pio_read_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 2,
    parameter int PIO_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_read,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    output logic                  m0_waitrequest,
    output logic                  m0_readdatavalid,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    input  logic                  m1_read,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    output logic                  m1_waitrequest,
    output logic                  m1_readdatavalid,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic [ADDR_WIDTH-1:0] pio_address,
    input  logic [DATA_WIDTH-1:0] pio_readdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Counter value on the final WAIT cycle. The legal latency range (1-7) fits in 3 bits.
    localparam logic [2:0] LAT_LAST = 3'(PIO_LATENCY);

    logic [1:0]            state_q, state_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] pio_address_q, pio_address_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic                  gnt0, gnt1;

`ifndef PIO_ARB_FIXED_PRIO_EN
    // 1 means requester 1 was granted last. Reset value 0 lets requester 1 win the first tie.
    logic                  last_q, last_d;
`endif

    // Pick the winner among the requests that are currently asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef PIO_ARB_FIXED_PRIO_EN
        gnt0 = m0_read;
        gnt1 = m1_read & ~m0_read;
`else
        if (m0_read && m1_read) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else begin
            gnt0 = m0_read;
            gnt1 = m1_read;
        end
`endif
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        owner_d       = owner_q;
        pio_address_d = pio_address_q;
        rd0_d         = rd0_q;
        rd1_d         = rd1_q;
`ifndef PIO_ARB_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d       = ST_WAIT;
                    lat_cnt_d     = 3'd0;
                    owner_d       = gnt1;
                    pio_address_d = gnt1 ? m1_address : m0_address;
`ifndef PIO_ARB_FIXED_PRIO_EN
                    last_d        = gnt1;
`endif
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_RESPOND;
                    if (owner_q) begin
                        rd1_d = pio_readdata;
                    end else begin
                        rd0_d = pio_readdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update; reset takes priority and aborts any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lat_cnt_q     <= 3'd0;
            owner_q       <= 1'b0;
            pio_address_q <= '0;
            rd0_q         <= '0;
            rd1_q         <= '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
            last_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            owner_q       <= owner_d;
            pio_address_q <= pio_address_d;
            rd0_q         <= rd0_d;
            rd1_q         <= rd1_d;
`ifndef PIO_ARB_FIXED_PRIO_EN
            last_q        <= last_d;
`endif
        end
    end

    // Reset also gates the strobes, so an aborted read never reports data.
    assign m0_waitrequest   = ~(~reset & (state_q == ST_IDLE) & gnt0);
    assign m1_waitrequest   = ~(~reset & (state_q == ST_IDLE) & gnt1);
    assign m0_readdatavalid = ~reset & (state_q == ST_RESPOND) & ~owner_q;
    assign m1_readdatavalid = ~reset & (state_q == ST_RESPOND) & owner_q;
    assign m0_readdata      = rd0_q;
    assign m1_readdata      = rd1_q;
    assign pio_address      = pio_address_q;

endmodule
